tinytpu_host_link: RTL and testbench

Host-side master for the tinytpu bit-serial port. Takes parallel X and Y operand matrices from a controller, shifts them into the accelerator on `data_in_x`/`data_in_y` under `load_en`, pulses `init`, and then deserializes the result matrix streamed back on `data_out_z` while `tx_ready` is high. It sits opposite `tinytpu_top` on the same wires, either in an FPGA test harness or in a host SoC. It presents a single start/done handshake to its controller.

---
 rtl/tinytpu_host_link.sv | 183 ++++++++++++++++++
 tb/tb_tinytpu_host_link.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tinytpu_host_link.sv
// tinytpu_host_link: host-side master for the tinytpu bit-serial port.
// Serialises the X/Y operand matrices onto data_in_x/data_in_y, pulses init,
// then deserialises the result matrix streamed back on data_out_z.
module tinytpu_host_link #(
  parameter int D_W     = 8,
  parameter int N       = 2,
  parameter int R_W     = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*N*D_W-1:0]   x_data,
  input  logic [N*N*D_W-1:0]   y_data,
  output logic                 busy,
  output logic [N*N*R_W-1:0]   z_data,
  output logic                 z_valid,
  output logic                 err,
  output logic                 load_en,
  output logic                 data_in_x,
  output logic                 data_in_y,
  output logic                 init,
  input  logic                 data_out_z,
  input  logic                 tx_ready
);

  localparam int X_BITS   = N * N * D_W;
  localparam int Z_BITS   = N * N * R_W;
  localparam int MAX_BITS = (X_BITS > Z_BITS) ? X_BITS : Z_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int TO_W     = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(X_BITS);
  localparam logic [CNT_W-1:0] Z_LAST  = CNT_W'(Z_BITS - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_INIT,
    S_WAIT,
    S_RECV,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [X_BITS-1:0]   x_sr_q;
  logic [X_BITS-1:0]   y_sr_q;
  logic [Z_BITS-2:0]   rx_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic                busy_q;
  logic [Z_BITS-1:0]   z_data_q;
  logic                z_valid_q;
  logic                err_q;
  logic                load_en_q;
  logic                data_in_x_q;
  logic                data_in_y_q;
  logic                init_q;

  // Operands reordered into wire order: stream bit 0 sits at the MSB so the
  // shift register always emits its top bit (element 0 first, MSB first).
  logic [X_BITS-1:0]   x_ser;
  logic [X_BITS-1:0]   y_ser;
  // Receive register including the bit being captured this cycle.
  logic [Z_BITS-1:0]   rx_d;
  // Result matrix unpacked from the received stream into element order.
  logic [Z_BITS-1:0]   z_unpack;

  assign rx_d = {rx_q, data_out_z};

  for (genvar gi = 0; gi < N * N; gi++) begin : g_elem
    for (genvar gb = 0; gb < D_W; gb++) begin : g_opbit
      assign x_ser[X_BITS-1-(gi*D_W+gb)] = x_data[gi*D_W + D_W-1-gb];
      assign y_ser[X_BITS-1-(gi*D_W+gb)] = y_data[gi*D_W + D_W-1-gb];
    end
    for (genvar gb = 0; gb < R_W; gb++) begin : g_resbit
      assign z_unpack[gi*R_W + R_W-1-gb] = rx_d[Z_BITS-1-(gi*R_W+gb)];
    end
  end

  // Transaction FSM with every output registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_sr_q      <= '0;
      y_sr_q      <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      busy_q      <= 1'b0;
      z_data_q    <= '0;
      z_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      load_en_q   <= 1'b0;
      data_in_x_q <= 1'b0;
      data_in_y_q <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      z_valid_q <= 1'b0;
      err_q     <= 1'b0;
      init_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // The first bit goes out immediately, so the count starts at one.
            data_in_x_q <= x_ser[X_BITS-1];
            data_in_y_q <= y_ser[X_BITS-1];
            x_sr_q      <= {x_ser[X_BITS-2:0], 1'b0};
            y_sr_q      <= {y_ser[X_BITS-2:0], 1'b0};
            load_en_q   <= 1'b1;
            bit_cnt_q   <= CNT_W'(1);
            busy_q      <= 1'b1;
            state_q     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_cnt_q == X_LAST) begin
            load_en_q   <= 1'b0;
            data_in_x_q <= 1'b0;
            data_in_y_q <= 1'b0;
            init_q      <= 1'b1;
            state_q     <= S_INIT;
          end else begin
            data_in_x_q <= x_sr_q[X_BITS-1];
            data_in_y_q <= y_sr_q[X_BITS-1];
            x_sr_q      <= {x_sr_q[X_BITS-2:0], 1'b0};
            y_sr_q      <= {y_sr_q[X_BITS-2:0], 1'b0};
            bit_cnt_q   <= bit_cnt_q + 1'b1;
          end
        end
        S_INIT: begin
          to_cnt_q  <= '0;
          bit_cnt_q <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_ready) begin
            rx_q      <= rx_d[Z_BITS-2:0];
            bit_cnt_q <= CNT_W'(1);
            state_q   <= S_RECV;
          end else if (to_cnt_q == TO_LAST) begin
            // Give up: z_data keeps the last good result.
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_RECV: begin
          // tx_ready low is a stall: hold the count, no timeout here.
          if (tx_ready) begin
            rx_q      <= rx_d[Z_BITS-2:0];
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == Z_LAST) begin
              z_data_q  <= z_unpack;
              z_valid_q <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign z_data    = z_data_q;
  assign z_valid   = z_valid_q;
  assign err       = err_q;
  assign load_en   = load_en_q;
  assign data_in_x = data_in_x_q;
  assign data_in_y = data_in_y_q;
  assign init      = init_q;

endmodule

// File: tb/tb_tinytpu_host_link.sv
// Directed bench for tinytpu_host_link with a small behavioural TPU responder.
module tb_tinytpu_host_link;

  localparam logic [31:0] X_BASIC = 32'h04030201;  // X=[1,2;3,4]
  localparam logic [31:0] Y_BASIC = 32'h08070605;  // Y=[5,6;7,8]
  localparam logic [63:0] Z_BASIC = 64'h0032002B00160013;  // [19,22;43,50]
  localparam logic [31:0] X_TWO   = 32'h02000002;  // X=[2,0;0,2]
  localparam logic [63:0] Z_TWO   = 64'h0010000E000C000A;  // [10,12;14,16]

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] x_data;
  logic [31:0] y_data;
  logic        busy;
  logic [63:0] z_data;
  logic        z_valid;
  logic        err;
  logic        load_en;
  logic        data_in_x;
  logic        data_in_y;
  logic        init;
  logic        data_out_z;
  logic        tx_ready;

  tinytpu_host_link #(
    .D_W(8), .N(2), .R_W(16), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_data(x_data), .y_data(y_data),
    .busy(busy), .z_data(z_data), .z_valid(z_valid), .err(err),
    .load_en(load_en), .data_in_x(data_in_x), .data_in_y(data_in_y),
    .init(init), .data_out_z(data_out_z), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int          cyc = 0;
  int          ln_cnt = 0, init_cnt = 0, zv_cnt = 0, err_cnt = 0;
  int          le_rise_cyc = 0, last_le_cyc = 0, init_cyc = 0, zv_cyc = 0, err_cyc = 0;
  logic        le_prev = 1'b0;
  logic        err_busy = 1'b0;
  logic [31:0] xs = '0;
  logic [31:0] ys = '0;
  logic [63:0] z_at_valid = '0;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    le_prev <= load_en;
    if (load_en) begin
      xs          <= {xs[30:0], data_in_x};
      ys          <= {ys[30:0], data_in_y};
      ln_cnt      <= ln_cnt + 1;
      last_le_cyc <= cyc + 1;
      if (!le_prev) le_rise_cyc <= cyc + 1;
    end
    if (init) begin
      init_cnt <= init_cnt + 1;
      init_cyc <= cyc + 1;
    end
    if (z_valid) begin
      zv_cnt     <= zv_cnt + 1;
      zv_cyc     <= cyc + 1;
      z_at_valid <= z_data;
    end
    if (err) begin
      err_cnt  <= err_cnt + 1;
      err_cyc  <= cyc + 1;
      err_busy <= busy;
    end
  end

  // ---------------- TPU responder ----------------
  logic        tpu_en = 1'b0;
  logic        tpu_stall = 1'b0;
  logic [63:0] tpu_z = '0;

  initial begin
    tx_ready   = 1'b0;
    data_out_z = 1'b0;
  end

  // Ten cycles after init, stream the result MSB first, element 0 first;
  // optionally stall 5 cycles after the 7th, 30th and 63rd bits.
  always begin
    @(negedge clk);
    if (init && tpu_en) begin
      repeat (10) @(negedge clk);
      for (int s = 0; s < 64; s++) begin
        tx_ready   = 1'b1;
        data_out_z = tpu_z[(s / 16) * 16 + 15 - (s % 16)];
        @(negedge clk);
        if (tpu_stall && (s == 6 || s == 29 || s == 62)) begin
          tx_ready   = 1'b0;
          data_out_z = 1'b0;
          repeat (5) @(negedge clk);
        end
      end
      tx_ready   = 1'b0;
      data_out_z = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] wire_order(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic pulse_start(input logic [31:0] x, input logic [31:0] y);
    x_data = x;
    y_data = y;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_zv(input int base, input int budget);
    int i = 0;
    while (zv_cnt == base && i < budget) begin
      tick();
      i++;
    end
  endtask

  // One full transaction; inject=1 pulses a bogus start mid-shift.
  task automatic run_txn(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] zexp, input int zv_lat, input bit inject);
    int zv0 = zv_cnt;
    int ln0 = ln_cnt;
    int in0 = init_cnt;
    int er0 = err_cnt;
    int i = 0;
    tpu_z = zexp;
    pulse_start(x, y);
    if (inject) begin
      while (ln_cnt - ln0 < 10 && i < 40) begin
        tick();
        i++;
      end
      x_data = 32'hFFFFFFFF;
      y_data = 32'hFFFFFFFF;
      start  = 1'b1;
      tick();
      start  = 1'b0;
    end
    wait_zv(zv0, 300);
    chk({tag, "_zv_seen"}, 64'(zv_cnt - zv0), 64'd1);
    chk({tag, "_xstream"}, 64'(xs), 64'(wire_order(x)));
    chk({tag, "_ystream"}, 64'(ys), 64'(wire_order(y)));
    chk({tag, "_load_bits"}, 64'(ln_cnt - ln0), 64'd32);
    chk({tag, "_init_after_load"}, 64'(init_cyc - last_le_cyc), 64'd1);
    chk({tag, "_init_lat"}, 64'(init_cyc - le_rise_cyc), 64'd32);
    chk({tag, "_init_once"}, 64'(init_cnt - in0), 64'd1);
    chk({tag, "_zv_lat"}, 64'(zv_cyc - init_cyc), 64'(zv_lat));
    chk({tag, "_z"}, z_at_valid, zexp);
    tick();
    chk({tag, "_zv_busy_after"}, {62'd0, z_valid, busy}, 64'd0);
    repeat (3) tick();
    chk({tag, "_zv_count"}, 64'(zv_cnt - zv0), 64'd1);
    chk({tag, "_no_err"}, 64'(err_cnt - er0), 64'd0);
    chk({tag, "_z_hold"}, z_data, zexp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int zv0, er0, ln0, i, first_zv;
    rst_n  = 1'b0;
    start  = 1'b0;
    x_data = '0;
    y_data = '0;
    repeat (3) tick();
    chk("reset_outs", {57'd0, busy, z_valid, err, load_en, data_in_x, data_in_y, init}, 64'd0);
    chk("reset_z", z_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic multiply
    tpu_en = 1'b1;
    run_txn("basic", X_BASIC, Y_BASIC, Z_BASIC, 74, 1'b0);

    // Stalled receive: three 5-cycle stalls delay z_valid by 15
    tpu_stall = 1'b1;
    run_txn("stall", X_BASIC, Y_BASIC, Z_BASIC, 89, 1'b0);
    tpu_stall = 1'b0;

    // Timeout: no tx_ready at all
    tpu_en = 1'b0;
    zv0 = zv_cnt;
    er0 = err_cnt;
    pulse_start(X_TWO, Y_BASIC);
    i = 0;
    while (err_cnt == er0 && i < 100) begin
      tick();
      i++;
    end
    chk("to_err_seen", 64'(err_cnt - er0), 64'd1);
    chk("to_err_lat", 64'(err_cyc - init_cyc), 64'd17);
    chk("to_busy_low", {63'd0, err_busy}, 64'd0);
    chk("to_z_kept", z_data, Z_BASIC);
    tick();
    chk("to_err_pulse", {63'd0, err}, 64'd0);
    repeat (3) tick();
    chk("to_err_once", 64'(err_cnt - er0), 64'd1);
    chk("to_no_zv", 64'(zv_cnt - zv0), 64'd0);
    tpu_en = 1'b1;
    run_txn("after_to", X_TWO, Y_BASIC, Z_TWO, 74, 1'b0);

    // Reset during SHIFT at the 12th operand bit
    zv0 = zv_cnt;
    er0 = err_cnt;
    ln0 = ln_cnt;
    tpu_z = Z_BASIC;
    pulse_start(X_BASIC, Y_BASIC);
    i = 0;
    while (ln_cnt - ln0 < 12 && i < 40) begin
      tick();
      i++;
    end
    rst_n = 1'b0;
    tick();
    chk("rst_outs", {57'd0, busy, z_valid, err, load_en, data_in_x, data_in_y, init}, 64'd0);
    chk("rst_z", z_data, 64'd0);
    rst_n = 1'b1;
    repeat (100) tick();
    chk("rst_no_zv_err", {32'(zv_cnt - zv0), 32'(err_cnt - er0)}, 64'd0);
    run_txn("post_rst", X_BASIC, Y_BASIC, Z_BASIC, 74, 1'b0);

    // Busy rejection: a start with all-0xFF operands mid-shift is ignored
    run_txn("busy_rej", X_BASIC, Y_BASIC, Z_BASIC, 74, 1'b1);

    // Back-to-back with start held high
    zv0 = zv_cnt;
    tpu_z  = Z_BASIC;
    x_data = X_BASIC;
    y_data = Y_BASIC;
    start  = 1'b1;
    wait_zv(zv0, 300);
    chk("b2b_first_seen", 64'(zv_cnt - zv0), 64'd1);
    chk("b2b_first_z", z_at_valid, Z_BASIC);
    first_zv = zv_cyc;
    x_data = X_TWO;
    tpu_z  = Z_TWO;
    i = 0;
    while (le_rise_cyc <= first_zv && i < 10) begin
      tick();
      i++;
    end
    // One idle cycle separates the z_valid cycle and the next load_en.
    chk("b2b_gap", 64'(le_rise_cyc - first_zv), 64'd2);
    start = 1'b0;
    wait_zv(zv0 + 1, 300);
    chk("b2b_second_seen", 64'(zv_cnt - zv0), 64'd2);
    chk("b2b_second_x", 64'(xs), 64'(wire_order(X_TWO)));
    chk("b2b_second_lat", 64'(zv_cyc - le_rise_cyc), 64'd106);
    chk("b2b_second_z", z_at_valid, Z_TWO);
    repeat (5) tick();
    chk("b2b_idle", {62'd0, busy, load_en}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
